// File: rtl/rep_pulse_sched.sv
// rep_pulse_sched: a/b pulse-train scheduler for the repetition-operator examples.
// One start/reps request produces a single a pulse, then reps b pulses spaced by
// fixed idle gaps, then a single done pulse.
//
// Ports:
//   clk      - clock, all logic on posedge
//   rst      - synchronous reset, active-high
//   start    - sequence request, sampled only in IDLE (and DONE when chaining)
//   reps     - number of b pulses requested, sampled with start
//   busy     - high from the cycle after an accepted start through the done cycle
//   a        - single-cycle a pulse
//   b        - single-cycle b pulses
//   done     - single-cycle completion pulse
//   b_count  - b pulses issued in the current or last sequence
//
// Optional feature macro: REP_PULSE_SCHED_CHAIN_EN
//   When defined, a start with reps!=0 seen in DONE launches the next sequence
//   directly, so a follows done with no idle cycle and busy never drops.
module rep_pulse_sched #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned A_TO_B_GAP = 3,
  parameter int unsigned B_TO_B_GAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] reps,
  output logic             busy,
  output logic             a,
  output logic             b,
  output logic             done,
  output logic [CNT_W-1:0] b_count
);

  localparam int unsigned GAP_MAX = (A_TO_B_GAP > B_TO_B_GAP) ? A_TO_B_GAP : B_TO_B_GAP;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_A     = 3'd1;
  localparam logic [2:0] S_GAP_A = 3'd2;
  localparam logic [2:0] S_B     = 3'd3;
  localparam logic [2:0] S_GAP_B = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Gaps below these minimums would break the b-spacing trace constraints.
  if (A_TO_B_GAP < 3) begin : g_bad_a_gap
    $fatal(1, "rep_pulse_sched: A_TO_B_GAP must be >= 3");
  end
  if (B_TO_B_GAP < 1) begin : g_bad_b_gap
    $fatal(1, "rep_pulse_sched: B_TO_B_GAP must be >= 1");
  end

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [GAP_W-1:0] gap, gap_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept_c;

  assign accept_c = start && (reps != '0);

  // Next-state and datapath updates.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    gap_nxt   = gap;
    cnt_nxt   = b_count;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          state_nxt = S_A;
          rem_nxt   = reps;
          cnt_nxt   = '0;
        end
      end
      S_A: begin
        state_nxt = S_GAP_A;
        gap_nxt   = GAP_W'(A_TO_B_GAP);
      end
      S_GAP_A: begin
        // Gap counter counts down to 1 so the state lasts exactly A_TO_B_GAP cycles.
        if (gap == GAP_W'(1)) state_nxt = S_B;
        else                  gap_nxt   = gap - GAP_W'(1);
      end
      S_B: begin
        rem_nxt = rem - CNT_W'(1);
        if (rem == CNT_W'(1)) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_GAP_B;
          gap_nxt   = GAP_W'(B_TO_B_GAP);
        end
      end
      S_GAP_B: begin
        if (gap == GAP_W'(1)) state_nxt = S_B;
        else                  gap_nxt   = gap - GAP_W'(1);
      end
      S_DONE: begin
`ifdef REP_PULSE_SCHED_CHAIN_EN
        if (accept_c) begin
          state_nxt = S_A;
          rem_nxt   = reps;
          cnt_nxt   = '0;
        end else begin
          state_nxt = S_IDLE;
        end
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
    // b_count tracks the pulse being issued; cannot wrap since it never exceeds reps.
    if (state_nxt == S_B) cnt_nxt = cnt_nxt + CNT_W'(1);
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rem     <= '0;
      gap     <= '0;
      b_count <= '0;
      busy    <= 1'b0;
      a       <= 1'b0;
      b       <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      rem     <= rem_nxt;
      gap     <= gap_nxt;
      b_count <= cnt_nxt;
      busy    <= (state_nxt != S_IDLE);
      a       <= (state_nxt == S_A);
      b       <= (state_nxt == S_B);
      done    <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: doc/rep_pulse_sched.md
Name: rep_pulse_sched

Overview:
- Stimulus scheduler for the repetition-operator examples.
- Produces the a/b pulse train that the consecutive ([*N]) and goto ([->N]) covers observe. The generated train always meets the team's trace constraints:
  - b stays low for at least 4 cycles starting with the a cycle;
  - b is never high on two consecutive cycles.
- Simulation and formal harnesses drive it with a single start/reps request and wait for done.

Parameters:
- CNT_W, 4: width of the reps request and of b_count.
- A_TO_B_GAP, 3: idle cycles between the a pulse and the first b pulse. Legal values ≥3.
- B_TO_B_GAP, 1: idle cycles between consecutive b pulses. Legal values ≥1.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a sequence; sampled only in IDLE.
- reps  input  CNT_W  number of b pulses requested; sampled with start.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- a  output  1  single-cycle a pulse.
- b  output  1  single-cycle b pulses.
- done  output  1  single-cycle completion pulse.
- b_count  output  CNT_W  number of b pulses issued in the current or last sequence.

Behaviour:
- Reset:
  - rst high at a posedge → next cycle: state IDLE; busy, a, b, done = 0; b_count = 0.
  - Reset mid-sequence aborts immediately. No done pulse is issued for the aborted sequence.
- FSM states: IDLE, A, GAP_A, B, GAP_B, DONE. All outputs are registered.
- IDLE:
  - start=1 and reps≠0 at cycle t → latch reps into rem, clear b_count, go to A.
  - start=1 with reps=0 → ignored; stay in IDLE, no outputs change.
- A: a=1, busy=1, one cycle → GAP_A with the gap counter loaded to A_TO_B_GAP.
- GAP_A: a=0, b=0. Counter decrements each cycle; after A_TO_B_GAP cycles → B.
- B: b=1 for one cycle; b_count increments; rem decrements.
  - rem (before decrement) = 1 → DONE.
  - Otherwise → GAP_B with the counter loaded to B_TO_B_GAP.
- GAP_B: b=0 for B_TO_B_GAP cycles → B.
- DONE: done=1, busy=1, for one cycle → IDLE. b_count holds its value until the next accepted start.
- Timing, start accepted at cycle 0:
  - a at cycle 1;
  - b at cycles 2+A_TO_B_GAP+k·(B_TO_B_GAP+1), for k=0..reps−1;
  - done one cycle after the last b.
- a and b are never high in the same cycle. a is high exactly once per sequence.
- start while busy is ignored and not queued. reps changes while busy have no effect.
- reps = 2^CNT_W−1 is legal. b_count reaches that value without wrap.
- Illegal parameters (A_TO_B_GAP<3 or B_TO_B_GAP<1) are rejected by an elaboration-time $fatal.

Optional Feature:
- Macro: REP_PULSE_SCHED_CHAIN_EN.
- Defined:
  - In DONE, if start=1 and reps≠0, the FSM goes directly to A with the new reps latched. b_count is cleared.
  - done and the new a are then separated by zero idle cycles (a is asserted in the cycle after done), and busy stays high throughout.
  - start=1 with reps=0 in DONE → IDLE as normal.
- Undefined: DONE always → IDLE. A new start is accepted no earlier than the cycle after done, so a appears no earlier than 2 cycles after done.

Test Plan:
- Reset, then start=1 with reps=3 at cycle 0 (defaults) → a@1; b@5,7,9; done@10; busy high over 1..10; b_count=3 after cycle 9.
- start=1 with reps=0 → busy, a, b and done stay 0 for 20 cycles; b_count unchanged.
- reps=2 accepted; start pulsed again at cycle 4 with reps=5 → ignored; exactly 2 b pulses (cycles 5 and 7); done@8.
- rst asserted at cycle 6 of a reps=4 sequence → from cycle 7: all outputs 0, state IDLE, no done. A new start at cycle 10 runs normally.
- A_TO_B_GAP=5, B_TO_B_GAP=2, reps=2 → a@1; b@7,10; done@11. Checker confirms a ∧ b never both high, b never high on consecutive cycles, and b low for the 4 cycles from the a cycle.
- With REP_PULSE_SCHED_CHAIN_EN: start held high, reps=1 → a@1, b@5, done@6, a@7, b@11, done@12; busy never drops. Without the macro, the same stimulus gives the second a@8.
